// File: rtl/vga_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_pkg
// Description : 640x480@60 timing constants, pixel/coordinate types and the
//               colour-bar lookup shared by the VGA scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_scan_pkg;

  localparam int c_h_visible = 640;
  localparam int c_h_front   = 16;
  localparam int c_h_sync    = 96;
  localparam int c_h_back    = 48;
  localparam int c_v_visible = 480;
  localparam int c_v_front   = 10;
  localparam int c_v_sync    = 2;
  localparam int c_v_back    = 33;

  localparam int c_h_total    = c_h_visible + c_h_front + c_h_sync + c_h_back;
  localparam int c_v_total    = c_v_visible + c_v_front + c_v_sync + c_v_back;
  localparam int c_hs_start   = c_h_visible + c_h_front;
  localparam int c_hs_end     = c_hs_start + c_h_sync;
  localparam int c_vs_start   = c_v_visible + c_v_front;
  localparam int c_vs_end     = c_vs_start + c_v_sync;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Classic SMPTE-style bar order, left to right.
  function automatic rgb_t bar_rgb(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
      3'd1:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
      3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
      3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
      3'd4:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
      3'd5:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
      3'd6:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
      default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_counter
// Description : Pixel clock divider and horizontal/vertical scan counters.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_counter
  import vga_scan_pkg::*;
#(
  parameter int H_TOTAL = c_h_total,
  parameter int V_TOTAL = c_v_total,
  parameter int CLK_DIV = 2
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   pixel_ce,
  output logic   frame_wrap,
  output coord_t hc,
  output coord_t vc,
  output logic   vga_clk
);

  localparam int c_div_w = $clog2(CLK_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);
  localparam coord_t c_h_last = coord_t'(H_TOTAL - 1);
  localparam coord_t c_v_last = coord_t'(V_TOTAL - 1);

  logic [c_div_w-1:0] r_div_cnt;
  logic [c_div_w-1:0] w_div_next;
  logic               r_vga_clk;
  coord_t             r_hc;
  coord_t             r_vc;
  logic               w_pixel_ce;
  logic               w_line_wrap;
  logic               w_frame_wrap;

  assign w_pixel_ce   = (r_div_cnt == c_div_last);
  assign w_div_next   = w_pixel_ce ? '0 : r_div_cnt + 1'b1;
  assign w_line_wrap  = w_pixel_ce && (r_hc == c_h_last);
  assign w_frame_wrap = w_line_wrap && (r_vc == c_v_last);

  // VGA_CLK is computed from the next divider value so the registered pin
  // tracks div_cnt >= CLK_DIV/2 with no extra cycle of lag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div_cnt <= '0;
      r_vga_clk <= 1'b0;
      r_hc      <= '0;
      r_vc      <= '0;
    end else begin
      r_div_cnt <= w_div_next;
      r_vga_clk <= (w_div_next >= c_div_half);
      if (w_pixel_ce) begin
        if (w_line_wrap) begin
          r_hc <= '0;
          r_vc <= w_frame_wrap ? '0 : r_vc + 1'b1;
        end else begin
          r_hc <= r_hc + 1'b1;
        end
      end
    end
  end

  assign pixel_ce   = w_pixel_ce;
  assign frame_wrap = w_frame_wrap;
  assign hc         = r_hc;
  assign vc         = r_vc;
  assign vga_clk    = r_vga_clk;

endmodule
`default_nettype wire

// File: rtl/vga_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_driver
// Description : VGA pixel-timing master: scan counters, sync/blank decode and
//               pixel-aligned DAC output registers. Define
//               VGA_SCAN_TEST_PATTERN_EN to replace renderer colour with bars.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_driver
  import vga_scan_pkg::*;
#(
  parameter int H_VISIBLE = c_h_visible,
  parameter int H_FRONT   = c_h_front,
  parameter int H_SYNC    = c_h_sync,
  parameter int H_BACK    = c_h_back,
  parameter int V_VISIBLE = c_v_visible,
  parameter int V_FRONT   = c_v_front,
  parameter int V_SYNC    = c_v_sync,
  parameter int V_BACK    = c_v_back,
  parameter int CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       pixel_ce,
  output logic       frame_start
);

  localparam int     c_h_tot   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int     c_v_tot   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t c_h_vis   = coord_t'(H_VISIBLE);
  localparam coord_t c_v_vis   = coord_t'(V_VISIBLE);
  localparam coord_t c_hs_beg  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t c_hs_stop = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t c_vs_beg  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t c_vs_stop = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  logic   w_pixel_ce;
  logic   w_frame_wrap;
  logic   w_vga_clk;
  coord_t w_hc;
  coord_t w_vc;
  logic   w_visible;
  logic   w_hs_raw;
  logic   w_vs_raw;
  rgb_t   w_src;

  rgb_t   r_rgb;
  logic   r_hs;
  logic   r_vs;
  logic   r_blank_n;
  logic   r_frame_start;

  vga_scan_counter #(
    .H_TOTAL (c_h_tot),
    .V_TOTAL (c_v_tot),
    .CLK_DIV (CLK_DIV)
  ) u_counter (
    .Clk        (Clk),
    .Reset      (Reset),
    .pixel_ce   (w_pixel_ce),
    .frame_wrap (w_frame_wrap),
    .hc         (w_hc),
    .vc         (w_vc),
    .vga_clk    (w_vga_clk)
  );

  assign w_visible = (w_hc < c_h_vis) && (w_vc < c_v_vis);
  assign w_hs_raw  = !((w_hc >= c_hs_beg) && (w_hc < c_hs_stop));
  assign w_vs_raw  = !((w_vc >= c_vs_beg) && (w_vc < c_vs_stop));

`ifdef VGA_SCAN_TEST_PATTERN_EN
  logic [2:0] w_bar;

  always_comb begin
    w_bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w_hc >= coord_t'(i * (H_VISIBLE / 8))) w_bar = 3'(i);
    end
  end

  assign w_src = bar_rgb(w_bar);
`else
  assign w_src = {Red, Green, Blue};
`endif

  // Colour, sync and blank share one register stage so they stay aligned.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rgb         <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (w_pixel_ce) begin
        r_rgb     <= w_visible ? w_src : '0;
        r_hs      <= w_hs_raw;
        r_vs      <= w_vs_raw;
        r_blank_n <= w_visible;
      end
    end
  end

  assign DrawX       = w_hc;
  assign DrawY       = w_vc;
  assign VGA_R       = r_rgb.r;
  assign VGA_G       = r_rgb.g;
  assign VGA_B       = r_rgb.b;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = w_vga_clk;
  assign pixel_ce    = w_pixel_ce;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_driver
// Description : Directed bench for vga_scan_driver on a shrunken raster
//               (46x19 total, 32x12 visible) so whole frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_driver;

  localparam int HV = 32, HF = 4, HSY = 6, HB = 4;
  localparam int VV = 12, VF = 2, VSY = 2, VB = 3;
  localparam int DIV = 2;
  localparam int HT = 46, VT = 19;
  localparam int LINE_CLK  = 92;    // 46 px * 2 Clk
  localparam int FRAME_CLK = 1748;  // 46 * 19 * 2

  logic       Clk, Reset;
  logic [7:0] Red, Green, Blue;
  logic [9:0] DrawX, DrawY;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
  logic       pixel_ce, frame_start;

  vga_scan_driver #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSY), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSY), .V_BACK (VB),
    .CLK_DIV   (DIV)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_CLK     (VGA_CLK),
    .pixel_ce    (pixel_ce),
    .frame_start (frame_start)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int xy_bad   = 0;
  int clk_bad  = 0;
  int fs_bad   = 0;
  int fs_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_xy(input string tag, input int x, input int y, input int budget);
    int n;
    n = 0;
    while (!(int'(DrawX) == x && int'(DrawY) == y) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check(tag, 32'(int'(DrawX) == x && int'(DrawY) == y), 1);
  endtask

  task automatic wait_cyc(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (cyc < target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check(tag, 32'(cyc >= target), 1);
  endtask

  task automatic check_pin(input string tag, input logic [23:0] rgb, input logic blank_n);
    check({tag, "_rgb"},   32'({VGA_R, VGA_G, VGA_B}), 32'(rgb));
    check({tag, "_blank"}, 32'(VGA_BLANK_N), 32'(blank_n));
  endtask

  // Expected colour of a visible pixel at column x given renderer input.
  function automatic logic [23:0] exp_vis(input int x, input logic [23:0] in);
`ifdef VGA_SCAN_TEST_PATTERN_EN
    logic [23:0] c;
    case (x / (HV / 8))
      0:       c = 24'hFFFFFF;
      1:       c = 24'hFFFF00;
      2:       c = 24'h00FFFF;
      3:       c = 24'h00FF00;
      4:       c = 24'hFF00FF;
      5:       c = 24'hFF0000;
      6:       c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return (in == in) ? c : c;
`else
    return (x >= 0) ? in : in;
`endif
  endfunction

  always @(posedge Clk) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Per-cycle model of counters, divider and frame pulse.
  always @(negedge Clk) begin
    #1;
    if (!Reset) begin
      if (int'(DrawX) != (cyc / DIV) % HT || int'(DrawY) != (cyc / DIV / HT) % VT) xy_bad++;
      if (VGA_CLK  != ((cyc % DIV) >= DIV / 2)) clk_bad++;
      if (pixel_ce != ((cyc % DIV) == DIV - 1)) clk_bad++;
      if (frame_start) begin
        fs_q.push_back(cyc);
        if (DrawX != 10'd0 || DrawY != 10'd0) fs_bad++;
      end
    end
  end

  initial begin
    int n;
    int fall;
    int q0;
    int q1;

    Reset = 1'b1;
    Red   = 8'hAB;
    Green = 8'h12;
    Blue  = 8'h34;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    check("rst_drawx", 32'(DrawX), 0);
    check("rst_drawy", 32'(DrawY), 0);
    check("rst_hs",    32'(VGA_HS), 1);
    check("rst_vs",    32'(VGA_VS), 1);
    check_pin("rst", 24'h000000, 1'b0);
    check("rst_ce",    32'(pixel_ce), 0);
    check("rst_vclk",  32'(VGA_CLK), 0);
    check("rst_fs",    32'(frame_start), 0);
    check("sync_n",    32'(VGA_SYNC_N), 0);
    step(1);
    check("ce_first",   32'(pixel_ce), 1);
    check("vclk_high",  32'(VGA_CLK), 1);
    check("x_hold",     32'(DrawX), 0);
    step(1);
    check("ce_low",     32'(pixel_ce), 0);
    check("x_advance",  32'(DrawX), 1);

    // Horizontal sync: raw low at hc 36..41, pin one pixel later.
    wait_xy("reach_hs", 36, 0, 200);
    check("hs_pre",  32'(VGA_HS), 1);
    step(1);
    check("hs_mid",  32'(VGA_HS), 1);
    step(1);
    check("hs_fall", 32'(VGA_HS), 0);
    fall = cyc;
    n = 0;
    while (VGA_HS == 1'b0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("hs_width", 32'(n), 12);
    n = 0;
    while (VGA_HS == 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("line_period", 32'(cyc - fall), LINE_CLK);

    // Colour pass-through and blanking boundaries.
    wait_xy("reach_5_2", 5, 2, 400);
    step(2);
    check_pin("px_5_2", exp_vis(5, 24'hAB1234), 1'b1);
    wait_xy("reach_32_2", 32, 2, 400);
    check_pin("px_31_2", exp_vis(31, 24'hAB1234), 1'b1);
    step(2);
    check_pin("px_32_2", 24'h000000, 1'b0);
    Red = 8'h55; Green = 8'hAA; Blue = 8'h0F;
    wait_xy("reach_10_3", 10, 3, 400);
    step(2);
    check_pin("px_10_3", exp_vis(10, 24'h55AA0F), 1'b1);
    wait_xy("reach_3_11", 3, 11, 1200);
    step(2);
    check_pin("px_3_11", exp_vis(3, 24'h55AA0F), 1'b1);
    wait_xy("reach_3_12", 3, 12, 400);
    step(2);
    check_pin("px_3_12", 24'h000000, 1'b0);

    // Vertical sync: raw low on lines 14..15.
    wait_xy("reach_vs", 0, 14, 400);
    check("vs_pre",  32'(VGA_VS), 1);
    step(2);
    check("vs_fall", 32'(VGA_VS), 0);
    n = 0;
    while (VGA_VS == 1'b0 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    check("vs_width", 32'(n), 2 * LINE_CLK);

    // Two frame_start pulses, one frame apart.
    wait_cyc("run_2frames", 2 * FRAME_CLK + 4, 5000);
    q0 = (fs_q.size() > 0) ? fs_q[0] : -1;
    q1 = (fs_q.size() > 1) ? fs_q[1] : -1;
    check("fs_count", 32'(fs_q.size()), 2);
    check("fs_first", 32'(q0), FRAME_CLK);
    check("fs_spacing", 32'(q1 - q0), FRAME_CLK);

    // Reset in the middle of a frame.
    wait_xy("reach_mid", 20, 7, 2000);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    fs_q.delete();
    check("mid_drawx", 32'(DrawX), 0);
    check("mid_drawy", 32'(DrawY), 0);
    check("mid_hs",    32'(VGA_HS), 1);
    check("mid_vs",    32'(VGA_VS), 1);
    check_pin("mid", 24'h000000, 1'b0);
    check("mid_ce",    32'(pixel_ce), 0);
    check("mid_fs",    32'(frame_start), 0);
    wait_cyc("run_after_mid", FRAME_CLK + 4, 3000);
    q0 = (fs_q.size() > 0) ? fs_q[0] : -1;
    check("mid_fs_count", 32'(fs_q.size()), 1);
    check("mid_fs_first", 32'(q0), FRAME_CLK);

    check("xy_track",  32'(xy_bad), 0);
    check("clk_track", 32'(clk_bad), 0);
    check("fs_origin", 32'(fs_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
